// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares a byte-wide, single-port synchronous memory between the
//   instruction-fetch requester (if_*) and the load/store requester (d_*).
//   Each 16-bit little-endian word access is sequenced as two byte beats:
//   IDLE -> LO (beat a) -> HI (beat a+1) -> LAST -> IDLE (result presented).
//   Every output is registered.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   halt            blocks new grants; an access already in flight completes
//   if_req/if_addr  fetch word-read request (held until if_gnt)
//   if_gnt          one-cycle pulse, high during the LO cycle of a fetch
//   if_rvalid       one-cycle pulse, if_rdata = {mem[a+1], mem[a]}
//   d_req/d_we      data request (held until d_gnt), 1 = write word
//   d_addr/d_wdata  data byte address / write word (low byte -> a)
//   d_gnt           one-cycle pulse, high during the LO cycle of a data access
//   d_done          one-cycle pulse, access complete (read: d_rdata valid)
//   mem_*           byte memory port; mem_rdata returns one cycle after mem_rd
//
// Configuration
//   MEM_ARB_RR_EN   when defined, simultaneous requests are resolved by a
//                   1-bit round-robin pointer reset to RR_INIT
//                   (0 = data favoured, 1 = fetch favoured); otherwise data
//                   always wins a tie.

module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 16,
    parameter bit          RR_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [15:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [15:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [15:0]       d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    typedef enum logic [1:0] {IDLE, LO, HI, LAST} state_t;

    state_t      state_q;
    logic        sel_data_q;   // owner of the access in flight: 1 = data port
    logic        we_q;
    logic [7:0]  wdata_hi_q;
    logic [7:0]  lo_q;         // low byte of a read, captured in the HI->LAST step

    logic        grant_d;
    logic        pick_data_d;

`ifdef MEM_ARB_RR_EN
    logic ptr_q;               // 0: data favoured on a tie, 1: fetch favoured

    always_comb begin
        pick_data_d = d_req && (!if_req || !ptr_q);
    end

    // Any grant hands preference to the requester that did not win.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= RR_INIT;
        end else if (grant_d) begin
            ptr_q <= pick_data_d;
        end
    end
`else
    logic unused_rr_init;
    assign unused_rr_init = RR_INIT;

    always_comb begin
        pick_data_d = d_req;
    end
`endif

    always_comb begin
        grant_d = (state_q == IDLE) && !halt && (d_req || if_req);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sel_data_q <= 1'b0;
            we_q       <= 1'b0;
            wdata_hi_q <= '0;
            lo_q       <= '0;
            if_gnt     <= 1'b0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            d_gnt      <= 1'b0;
            d_done     <= 1'b0;
            d_rdata    <= '0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_wdata  <= '0;
        end else begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_done    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q    <= LO;
                        sel_data_q <= pick_data_d;
                        if (pick_data_d) begin
                            d_gnt      <= 1'b1;
                            we_q       <= d_we;
                            wdata_hi_q <= d_wdata[15:8];
                            mem_addr   <= d_addr;
                            mem_rd     <= !d_we;
                            mem_wr     <= d_we;
                            mem_wdata  <= d_wdata[7:0];
                        end else begin
                            if_gnt     <= 1'b1;
                            we_q       <= 1'b0;
                            mem_addr   <= if_addr;
                            mem_rd     <= 1'b1;
                            mem_wr     <= 1'b0;
                        end
                    end
                end
                LO: begin
                    // Strobes stay asserted for the high beat; address wraps at ADDR_W bits.
                    state_q  <= HI;
                    mem_addr <= mem_addr + 1'b1;
                    if (we_q) begin
                        mem_wdata <= wdata_hi_q;
                    end
                end
                HI: begin
                    state_q <= LAST;
                    mem_rd  <= 1'b0;
                    mem_wr  <= 1'b0;
                    lo_q    <= mem_rdata;
                end
                LAST: begin
                    state_q <= IDLE;
                    if (sel_data_q) begin
                        d_done <= 1'b1;
                        if (!we_q) begin
                            d_rdata <= {mem_rdata, lo_q};
                        end
                    end else begin
                        if_rvalid <= 1'b1;
                        if_rdata  <= {mem_rdata, lo_q};
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt = 1'b0;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [15:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_gnt, d_done;
    logic [15:0] d_rdata;
    logic [15:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    typedef struct packed {
        logic        we;
        logic [15:0] data;
    } dexp_t;

    logic [15:0] exp_if_q[$];
    dexp_t       exp_d_q[$];

    logic [7:0]  mem [0:65535];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W (16),
        .RR_INIT(1'b0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .halt     (halt),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Byte memory with one-cycle read latency; image loaded while reset is held.
    always @(posedge clk) begin
        if (rst) begin
            mem[16'h0100] <= 8'h12;
            mem[16'h0101] <= 8'h34;
            mem[16'hFFFF] <= 8'hAA;
            mem[16'h0000] <= 8'h55;
            mem[16'h3000] <= 8'h11;
            mem[16'h3001] <= 8'h22;
            mem[16'h3100] <= 8'h33;
            mem[16'h3101] <= 8'h44;
        end else begin
            if (mem_rd) mem_rdata <= mem[mem_addr];
            if (mem_wr) mem[mem_addr] <= mem_wdata;
        end
    end

    // Scoreboard: every completion pulse pops and checks one expectation.
    always @(negedge clk) begin
        if (if_rvalid) begin
            vectors++;
            if (exp_if_q.size() == 0) begin
                miscompares++;
                $display("FAIL if_rvalid_unexpected: got rdata=%h, want no rvalid", if_rdata);
            end else begin
                logic [15:0] e;
                e = exp_if_q.pop_front();
                if (if_rdata !== e) begin
                    miscompares++;
                    $display("FAIL if_rdata: got %h, want %h", if_rdata, e);
                end
            end
        end
        if (d_done) begin
            vectors++;
            if (exp_d_q.size() == 0) begin
                miscompares++;
                $display("FAIL d_done_unexpected: got rdata=%h, want no done", d_rdata);
            end else begin
                dexp_t e;
                e = exp_d_q.pop_front();
                if (!e.we && d_rdata !== e.data) begin
                    miscompares++;
                    $display("FAIL d_rdata: got %h, want %h", d_rdata, e.data);
                end
            end
        end
    end

    // One complete access from an idle arbiter, checked beat by beat.
    task automatic run_access(input bit is_d, input bit we, input logic [15:0] a,
                              input logic [15:0] wd, input string nm);
        logic [15:0] a1;
        a1 = a + 16'd1;
        @(negedge clk);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        @(posedge clk); #1;
        vectors++;
        if ({if_gnt, d_gnt} !== {!is_d, is_d} || mem_addr !== a || mem_rd !== !we ||
            mem_wr !== we || (we && mem_wdata !== wd[7:0])) begin
            miscompares++;
            $display("FAIL %s_lo: got gnt(if,d)=%b%b addr=%h rd=%b wr=%b wdata=%h, want %b%b %h %b %b %h",
                     nm, if_gnt, d_gnt, mem_addr, mem_rd, mem_wr, mem_wdata,
                     !is_d, is_d, a, !we, we, wd[7:0]);
        end
        // Scramble inputs: they must be ignored after the grant edge.
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0; d_we = ~we; d_addr = ~a; if_addr = ~a; d_wdata = ~wd;
        @(posedge clk); #1;
        vectors++;
        if ({if_gnt, d_gnt} !== 2'b00 || mem_addr !== a1 || mem_rd !== !we ||
            mem_wr !== we || (we && mem_wdata !== wd[15:8])) begin
            miscompares++;
            $display("FAIL %s_hi: got gnt=%b%b addr=%h rd=%b wr=%b wdata=%h, want 00 %h %b %b %h",
                     nm, if_gnt, d_gnt, mem_addr, mem_rd, mem_wr, mem_wdata,
                     a1, !we, we, wd[15:8]);
        end
        @(posedge clk); #1;
        vectors++;
        if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || if_rvalid !== 1'b0 || d_done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_last: got rd=%b wr=%b rvalid=%b done=%b, want 0 0 0 0",
                     nm, mem_rd, mem_wr, if_rvalid, d_done);
        end
        @(posedge clk); #1;
        vectors++;
        if (if_rvalid !== !is_d || d_done !== is_d) begin
            miscompares++;
            $display("FAIL %s_done: got rvalid=%b done=%b, want %b %b",
                     nm, if_rvalid, d_done, !is_d, is_d);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({if_gnt, if_rvalid, if_rdata, d_gnt, d_done, d_rdata, mem_addr, mem_rd, mem_wr, mem_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_in: got outputs nonzero (addr=%h rd=%b wr=%b), want all 0",
                     mem_addr, mem_rd, mem_wr);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({if_gnt, if_rvalid, d_gnt, d_done, mem_rd, mem_wr, mem_addr} !== '0) begin
            miscompares++;
            $display("FAIL reset_out: got gnt=%b%b rd=%b wr=%b addr=%h, want all 0",
                     if_gnt, d_gnt, mem_rd, mem_wr, mem_addr);
        end
    endtask

    task automatic test_fetch();
        exp_if_q.push_back(16'h3412);
        run_access(1'b0, 1'b0, 16'h0100, 16'h0000, "fetch");
    endtask

    task automatic test_wrap();
        exp_if_q.push_back(16'h55AA);
        run_access(1'b0, 1'b0, 16'hFFFF, 16'h0000, "wrap");
    endtask

    task automatic test_write_readback();
        exp_d_q.push_back('{we: 1'b1, data: 16'h0000});
        run_access(1'b1, 1'b1, 16'h2000, 16'hBEEF, "write");
        vectors++;
        if (mem[16'h2000] !== 8'hEF || mem[16'h2001] !== 8'hBE) begin
            miscompares++;
            $display("FAIL write_mem: got %h %h, want ef be", mem[16'h2000], mem[16'h2001]);
        end
        exp_d_q.push_back('{we: 1'b0, data: 16'hBEEF});
        run_access(1'b1, 1'b0, 16'h2000, 16'h0000, "readback");
    endtask

    task automatic test_halt();
        exp_if_q.push_back(16'h3412);
        exp_d_q.push_back('{we: 1'b0, data: 16'h2211});
        @(negedge clk); if_req = 1'b1; if_addr = 16'h0100;
        @(posedge clk); #1;
        vectors++;
        if (if_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_gnt: got if_gnt=%b, want 1", if_gnt);
        end
        @(negedge clk); if_req = 1'b0; halt = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h3000;
        repeat (2) @(posedge clk);
        @(posedge clk); #1;
        vectors++;
        if (if_rvalid !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_complete: got if_rvalid=%b, want 1", if_rvalid);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({if_gnt, d_gnt} !== 2'b00) begin
                miscompares++;
                $display("FAIL halt_block: got gnt=%b%b at cycle %0d, want 00", if_gnt, d_gnt, i);
            end
        end
        @(negedge clk); halt = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (d_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_release: got d_gnt=%b, want 1", d_gnt);
        end
        @(negedge clk); d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (d_done !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_d_done: got d_done=%b, want 1", d_done);
        end
    endtask

    task automatic test_rst_abort();
        @(negedge clk); if_req = 1'b1; if_addr = 16'h0100;
        @(posedge clk);
        @(negedge clk); if_req = 1'b0;
        @(posedge clk); #2;
        vectors++;
        if (mem_rd !== 1'b1 || mem_addr !== 16'h0101) begin
            miscompares++;
            $display("FAIL abort_hi: got rd=%b addr=%h, want 1 0101", mem_rd, mem_addr);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== 16'h0000) begin
            miscompares++;
            $display("FAIL abort_strobe: got rd=%b wr=%b addr=%h, want 0 0 0000", mem_rd, mem_wr, mem_addr);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (if_rvalid !== 1'b0 || d_done !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_quiet: got rvalid=%b done=%b, want 0 0", if_rvalid, d_done);
            end
        end
        exp_if_q.push_back(16'h3412);
        run_access(1'b0, 1'b0, 16'h0100, 16'h0000, "after_rst");
    endtask

    task automatic test_contention();
        bit win_d [4];
        for (int g = 0; g < 4; g++) begin
`ifdef MEM_ARB_RR_EN
            win_d[g] = (g % 2) == 0;
`else
            win_d[g] = 1'b1;
`endif
            if (win_d[g]) exp_d_q.push_back('{we: 1'b0, data: 16'h2211});
            else          exp_if_q.push_back(16'h4433);
        end
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h3000; if_req = 1'b1; if_addr = 16'h3100;
        for (int k = 0; k < 16; k++) begin
            logic ed, ei;
            ed = (k % 4 == 0) &&  win_d[k / 4];
            ei = (k % 4 == 0) && !win_d[k / 4];
            @(posedge clk); #1;
            vectors++;
            if ({if_gnt, d_gnt} !== {ei, ed}) begin
                miscompares++;
                $display("FAIL contention_gnt: cycle %0d got gnt(if,d)=%b%b, want %b%b",
                         k, if_gnt, d_gnt, ei, ed);
            end
        end
        @(negedge clk); d_req = 1'b0; if_req = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, want finish before 50000");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch();
        test_wrap();
        test_write_readback();
        test_halt();
        test_rst_abort();
        test_contention();
        @(negedge clk);
        vectors++;
        if (exp_if_q.size() != 0 || exp_d_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d fetch and %0d data results outstanding, want 0 0",
                     exp_if_q.size(), exp_d_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
